// File: rtl/fifo_sync_param_pkg.sv
// fifo_sync_param_pkg: shared defaults and depth helper for the synchronous FIFO
package fifo_sync_param_pkg;
  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_ADDR_WIDTH = 3;
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction
endpackage

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: producer/consumer handshake and status bundle of the FIFO
interface fifo_sync_param_if
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_enable;
  logic                  error_clear;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic                  error;
  modport master (
    output write_enable, data_in, read_enable, error_clear,
    input  data_out, data_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow, error
  );
  modport slave (
    input  write_enable, data_in, read_enable, error_clear,
    output data_out, data_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow, error
  );
endinterface

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: dual-port RAM, synchronous write, registered read gated by re
module fifo_mem_dp
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rd
);
  logic [DATA_WIDTH-1:0] mem [depth_of(ADDR_WIDTH)];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // only the output register is reset; storage contents survive reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with count, almost flags, overflow/underflow and sticky error
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = depth_of(ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic clk,
  input logic reset,
  fifo_sync_param_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic full, empty, wr_ok, rd_ok, ovf, udf, valid_q, ovf_q, udf_q, err_q;
  always_comb begin
    full  = cnt == DEPTH_C;
    empty = cnt == '0;
    wr_ok = bus.write_enable && (!full || bus.read_enable);
    rd_ok = bus.read_enable && !empty;
    ovf   = bus.write_enable && full && !bus.read_enable;
    udf   = bus.read_enable && empty;
  end
  fifo_mem_dp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk(clk), .reset(reset),
    .we(wr_ok), .wa(wr_ptr), .wd(bus.data_in),
    .re(rd_ok), .ra(rd_ptr), .rd(rd_data)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      cnt     <= (wr_ok && !rd_ok) ? cnt + 1'b1 : (rd_ok && !wr_ok) ? cnt - 1'b1 : cnt;
      valid_q <= rd_ok;
      ovf_q   <= ovf;
      udf_q   <= udf;
      // a new violation outranks a simultaneous clear
      err_q   <= (ovf || udf) ? 1'b1 : bus.error_clear ? 1'b0 : err_q;
    end
  assign bus.data_out     = rd_data;
  assign bus.data_valid   = valid_q;
  assign bus.count        = cnt;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = cnt >= AF_C;
  assign bus.almost_empty = cnt <= AE_C;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
  assign bus.error        = err_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed stimulus with a read-data scoreboard and per-cycle status checks
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int passes = 0;
  int mcount = 0;
  bit merr = 1'b0;
  logic [9:0] mq[$];
  logic [9:0] exp_q[$];
  fifo_sync_param_if #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) bus ();
  fifo_sync_param dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask
  always @(posedge clk) begin
    #1;
    if (bus.data_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else check("data_out", {22'b0, bus.data_out}, {22'b0, exp_q.pop_front()});
    end
  end
  task automatic cycle(input bit we, input logic [9:0] d, input bit re, input bit ec);
    bit w_ok, r_ok, e_ovf, e_udf;
    bus.write_enable = we;
    bus.data_in      = d;
    bus.read_enable  = re;
    bus.error_clear  = ec;
    w_ok  = we && (mcount < 8 || re);
    r_ok  = re && mcount > 0;
    e_ovf = we && mcount == 8 && !re;
    e_udf = re && mcount == 0;
    if (r_ok) exp_q.push_back(mq.pop_front());
    if (w_ok) mq.push_back(d);
    mcount += int'(w_ok) - int'(r_ok);
    merr = (e_ovf || e_udf) ? 1'b1 : ec ? 1'b0 : merr;
    @(posedge clk);
    @(negedge clk);
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.error_clear  = 1'b0;
    check("count", bus.count, mcount);
    check("full", bus.full, mcount == 8);
    check("empty", bus.empty, mcount == 0);
    check("overflow", bus.overflow, e_ovf);
    check("underflow", bus.underflow, e_udf);
    check("error", bus.error, merr);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.error_clear  = 1'b0;
    bus.data_in      = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_ae", bus.almost_empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_af", bus.almost_full, 0);
    check("rst_valid", bus.data_valid, 0);
    check("rst_dout", bus.data_out, 0);
    check("rst_error", bus.error, 0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 10'(i), 0, 0);
      check("almost_full", bus.almost_full, i >= 7);
      check("almost_empty", bus.almost_empty, i <= 1);
    end
    check("filled_count", bus.count, 8);
    cycle(1, 10'h3FF, 0, 0);
    check("ovf_pulse", bus.overflow, 1);
    check("ovf_count", bus.count, 8);
    cycle(0, 0, 0, 0);
    check("ovf_single", bus.overflow, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);
    check("drained_empty", bus.empty, 1);
    check("drained_qlen", exp_q.size(), 0);
    cycle(0, 0, 0, 1);
    check("err_cleared", bus.error, 0);
    cycle(1, 10'h155, 1, 0);
    check("udf_pulse", bus.underflow, 1);
    check("udf_valid", bus.data_valid, 0);
    check("udf_count", bus.count, 1);
    cycle(0, 0, 1, 1);
    check("err_clr_ok", bus.error, 0);
    for (int i = 0; i < 3; i++) cycle(1, 10'h100 + 10'(i), 0, 0);
    for (int i = 3; i < 20; i++) begin
      cycle(1, 10'h100 + 10'(i), 1, 0);
      check("hold3", bus.count, 3);
    end
    for (int i = 0; i < 5; i++) cycle(1, 10'h200 + 10'(i), 0, 0);
    check("full_again", bus.full, 1);
    for (int i = 5; i < 9; i++) begin
      cycle(1, 10'h200 + 10'(i), 1, 0);
      check("hold_full", bus.count, 8);
    end
    cycle(1, 10'h3FF, 0, 1);
    check("err_set_wins", bus.error, 1);
    cycle(0, 0, 0, 1);
    check("err_clr2", bus.error, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check("wrap_qlen", exp_q.size(), 0);
    cycle(0, 0, 1, 0);
    cycle(1, 10'h0AA, 0, 0);
    cycle(1, 10'h0BB, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("async_count", bus.count, 0);
    check("async_empty", bus.empty, 1);
    check("async_error", bus.error, 0);
    mq.delete();
    mcount = 0;
    merr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cycle(1, 10'h2AA, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check("final_qlen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
